// File: rtl/f_fetch_stage.sv
// Fetch stage of the five-stage MIPS pipeline.
// Holds the PC, selects the next PC, and splits the IM word into decode fields.
module f_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LAST    = 32'h0000_6FFC,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_imm_16,
  input  logic [25:0] D_imm_26,
  input  logic [31:0] jr_target,
  input  logic        D_is_bj,
  input  logic [31:0] instr,
  output logic [31:0] i_addr,
  output logic [31:0] F_PC,
  output logic [5:0]  F_op,
  output logic [5:0]  F_fuc,
  output logic [4:0]  F_rs,
  output logic [4:0]  F_rt,
  output logic [4:0]  F_rd,
  output logic [4:0]  F_shamt,
  output logic [15:0] F_imm_16,
  output logic [25:0] F_imm_26,
  output logic [4:0]  F_EXEcode,
  output logic        F_delay_op
);

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] branch_off;
  logic        adel;
  logic        squash;
  logic        kill_fields;
  logic [31:0] instr_eff;

  assign branch_off = {{14{D_imm_16[15]}}, D_imm_16, 2'b00};

  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (req) begin
      pc_next = HANDLER_PC;
    end else if (stall) begin
      pc_next = pc_reg;
    end else if (eret) begin
      pc_next = epc;
    end else begin
      case (npc_sel)
        NPC_BRANCH: pc_next = D_PC + 32'd4 + branch_off;
        NPC_JUMP:   pc_next = {D_PC[31:28], D_imm_26, 2'b00};
        NPC_JR:     pc_next = jr_target;
        NPC_SEQ:    pc_next = pc_reg + 32'd4;
        default:    pc_next = pc_reg + 32'd4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // An eret in D means the word now in F is on the wrong path with no delay slot.
  assign squash      = eret & ~stall;
  assign adel        = (pc_reg[1:0] != 2'b00) || (pc_reg < IM_BASE) || (pc_reg > IM_LAST);
  assign kill_fields = adel | squash;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_mask
      assign instr_eff[gi] = instr[gi] & ~kill_fields;
    end
  endgenerate

  assign i_addr     = pc_reg;
  assign F_PC       = pc_reg;
  assign F_op       = instr_eff[31:26];
  assign F_rs       = instr_eff[25:21];
  assign F_rt       = instr_eff[20:16];
  assign F_rd       = instr_eff[15:11];
  assign F_shamt    = instr_eff[10:6];
  assign F_fuc      = instr_eff[5:0];
  assign F_imm_16   = instr_eff[15:0];
  assign F_imm_26   = instr_eff[25:0];
  assign F_EXEcode  = (adel && !squash) ? EXC_ADEL : 5'd0;
  assign F_delay_op = D_is_bj & ~squash;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed bench for f_fetch_stage: PC sequencing, redirects, AdEL and eret squash.
module tb_f_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [1:0]  npc_sel;
  logic [31:0] D_PC;
  logic [15:0] D_imm_16;
  logic [25:0] D_imm_26;
  logic [31:0] jr_target;
  logic        D_is_bj;
  logic [31:0] instr;
  logic [31:0] i_addr;
  logic [31:0] F_PC;
  logic [5:0]  F_op;
  logic [5:0]  F_fuc;
  logic [4:0]  F_rs;
  logic [4:0]  F_rt;
  logic [4:0]  F_rd;
  logic [4:0]  F_shamt;
  logic [15:0] F_imm_16;
  logic [25:0] F_imm_26;
  logic [4:0]  F_EXEcode;
  logic        F_delay_op;

  int n_checks = 0;
  int n_fail   = 0;

  f_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req        (req),
    .eret       (eret),
    .epc        (epc),
    .npc_sel    (npc_sel),
    .D_PC       (D_PC),
    .D_imm_16   (D_imm_16),
    .D_imm_26   (D_imm_26),
    .jr_target  (jr_target),
    .D_is_bj    (D_is_bj),
    .instr      (instr),
    .i_addr     (i_addr),
    .F_PC       (F_PC),
    .F_op       (F_op),
    .F_fuc      (F_fuc),
    .F_rs       (F_rs),
    .F_rt       (F_rt),
    .F_rd       (F_rd),
    .F_shamt    (F_shamt),
    .F_imm_16   (F_imm_16),
    .F_imm_26   (F_imm_26),
    .F_EXEcode  (F_EXEcode),
    .F_delay_op (F_delay_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock edge, then let outputs settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // op=0x23 rs=2 rt=3 rd=5 shamt=5 fuc=5
    instr     = 32'h8C43_2945;
    reset     = 1'b1;
    stall     = 1'b0;
    req       = 1'b0;
    eret      = 1'b0;
    epc       = 32'h0;
    npc_sel   = 2'd0;
    D_PC      = 32'h0;
    D_imm_16  = 16'h0;
    D_imm_26  = 26'h0;
    jr_target = 32'h0;
    D_is_bj   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_iaddr", i_addr, 32'h0000_3000);
    chk("rst_fpc", F_PC, 32'h0000_3000);
    chk("rst_exc", {27'd0, F_EXEcode}, 32'd0);
    chk("rst_bd", {31'd0, F_delay_op}, 32'd0);
    chk("rst_op", {26'd0, F_op}, 32'h23);
    chk("rst_rs_rt", {22'd0, F_rs, F_rt}, {22'd0, 5'd2, 5'd3});
    chk("rst_rd_sh", {22'd0, F_rd, F_shamt}, {22'd0, 5'd5, 5'd5});
    chk("rst_fuc", {26'd0, F_fuc}, 32'h5);
    chk("rst_imm16", {16'd0, F_imm_16}, 32'h2945);
    chk("rst_imm26", {6'd0, F_imm_26}, 32'h0432945);

    tick(); chk("seq_3004", i_addr, 32'h0000_3004);
    tick(); chk("seq_3008", i_addr, 32'h0000_3008);
    tick(); chk("seq_300c", i_addr, 32'h0000_300C);
    chk("seq_exc", {27'd0, F_EXEcode}, 32'd0);

    // Backward branch: 0x3010 + 4 - 16
    D_PC = 32'h0000_3010; D_imm_16 = 16'hFFFC; npc_sel = 2'd1; D_is_bj = 1'b1;
    #1;
    chk("br_bd", {31'd0, F_delay_op}, 32'd1);
    tick();
    chk("br_back", i_addr, 32'h0000_3004);
    D_imm_16 = 16'h0010;
    tick();
    chk("br_fwd", i_addr, 32'h0000_3054);
    npc_sel = 2'd0; D_is_bj = 1'b0;

    // Unaligned jr target: AdEL, fields nopped, BD still reported
    npc_sel = 2'd3; jr_target = 32'h0000_3002;
    tick();
    npc_sel = 2'd0; D_is_bj = 1'b1;
    #1;
    chk("adel_fpc", F_PC, 32'h0000_3002);
    chk("adel_exc", {27'd0, F_EXEcode}, 32'd4);
    chk("adel_op", {26'd0, F_op}, 32'd0);
    chk("adel_fuc", {26'd0, F_fuc}, 32'd0);
    chk("adel_imm26", {6'd0, F_imm_26}, 32'd0);
    chk("adel_bd", {31'd0, F_delay_op}, 32'd1);
    D_is_bj = 1'b0;

    // Upper boundary: last word legal, next word faults
    npc_sel = 2'd3; jr_target = 32'h0000_6FFC;
    tick();
    npc_sel = 2'd0;
    #1;
    chk("last_exc", {27'd0, F_EXEcode}, 32'd0);
    chk("last_op", {26'd0, F_op}, 32'h23);
    tick();
    chk("past_iaddr", i_addr, 32'h0000_7000);
    chk("past_exc", {27'd0, F_EXEcode}, 32'd4);

    // Lower boundary and 2^32 wrap
    npc_sel = 2'd3; jr_target = 32'h0000_2FFC;
    tick();
    chk("below_exc", {27'd0, F_EXEcode}, 32'd4);
    jr_target = 32'hFFFF_FFFC;
    tick();
    npc_sel = 2'd0;
    tick();
    chk("wrap_iaddr", i_addr, 32'h0000_0000);
    chk("wrap_exc", {27'd0, F_EXEcode}, 32'd4);

    // Stall holds PC against a pending jump; req overrides stall
    npc_sel = 2'd3; jr_target = 32'h0000_3100;
    tick();
    stall = 1'b1; npc_sel = 2'd2; D_PC = 32'hA000_0000; D_imm_26 = 26'h0000C10;
    tick(); chk("stall_1", i_addr, 32'h0000_3100);
    tick(); chk("stall_2", i_addr, 32'h0000_3100);
    req = 1'b1;
    tick(); chk("req_stall", i_addr, 32'h0000_4180);
    req = 1'b0; stall = 1'b0;
    tick(); chk("jump", i_addr, 32'hA000_3040);
    npc_sel = 2'd0;

    // Stalled eret: no squash, PC held
    eret = 1'b1; epc = 32'h0000_3040; stall = 1'b1; D_is_bj = 1'b1;
    #1;
    chk("eret_st_exc", {27'd0, F_EXEcode}, 32'd4);
    chk("eret_st_bd", {31'd0, F_delay_op}, 32'd1);
    tick();
    chk("eret_st_pc", i_addr, 32'hA000_3040);

    // Live eret: squash overrides AdEL and BD
    stall = 1'b0;
    #1;
    chk("sq_op", {26'd0, F_op}, 32'd0);
    chk("sq_rs_rt", {22'd0, F_rs, F_rt}, 32'd0);
    chk("sq_imm16", {16'd0, F_imm_16}, 32'd0);
    chk("sq_exc", {27'd0, F_EXEcode}, 32'd0);
    chk("sq_bd", {31'd0, F_delay_op}, 32'd0);
    chk("sq_fpc", F_PC, 32'hA000_3040);
    tick();
    chk("eret_pc", i_addr, 32'h0000_3040);
    eret = 1'b0; D_is_bj = 1'b0;
    #1;
    chk("post_eret_op", {26'd0, F_op}, 32'h23);

    // req beats eret; reset beats req
    req = 1'b1; eret = 1'b1;
    tick(); chk("req_eret", i_addr, 32'h0000_4180);
    eret = 1'b0; reset = 1'b1; npc_sel = 2'd3; jr_target = 32'h0000_5000;
    tick(); chk("rst_req", i_addr, 32'h0000_3000);
    reset = 1'b0; req = 1'b0; npc_sel = 2'd0;
    tick(); chk("after_rst", i_addr, 32'h0000_3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
